// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// Package: rv32i_types
// Purpose: Shared types for the decode queue: RV32I opcode set, immediate
//          format selector, ALU operation group, the control word handed to
//          execute, and the decoded FIFO entry. Also provides the immediate
//          generator used by the decoder.
// Contents:
//   DATA_W             width of pc/imm fields carried in a decoded entry
//   rv32i_opcode       major opcodes recognised as legal
//   FUNCT7_MULDIV      funct7 marking the M-extension group on op_reg
//   imm_format_t       immediate encoding format
//   alu_ops            ALU operation (funct3 encoding)
//   rv32i_control_word control bits consumed by execute (incl. muldiv)
//   decoded_entry_t    {ctrl, pc, imm, rs1, rs2, rd, illegal}
//   imm_gen()          sign-extended immediate for a given format
// ----------------------------------------------------------------------------
package rv32i_types;

    localparam int DATA_W = 32;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        fmt_none,
        fmt_i,
        fmt_s,
        fmt_b,
        fmt_u,
        fmt_j
    } imm_format_t;

    typedef enum logic [2:0] {
        alu_add  = 3'b000,
        alu_sll  = 3'b001,
        alu_slt  = 3'b010,
        alu_sltu = 3'b011,
        alu_xor  = 3'b100,
        alu_srl  = 3'b101,
        alu_or   = 3'b110,
        alu_and  = 3'b111
    } alu_ops;

    // All-zero value is the "do nothing" word: no writeback, no memory access.
    typedef struct packed {
        logic [6:0] opcode;
        alu_ops     aluop;
        logic       alt;          // sub / sra variant
        logic       alu_imm;      // operand 2 is the immediate
        logic       uses_rs1;
        logic       uses_rs2;
        logic       regfile_load;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       muldiv;
        logic [2:0] funct3;       // load/store width, branch compare, muldiv op
    } rv32i_control_word;

    typedef struct packed {
        rv32i_control_word ctrl;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              illegal;
    } decoded_entry_t;

    function automatic logic [DATA_W-1:0] imm_gen(input logic [31:0] instr,
                                                  input imm_format_t fmt);
        logic [DATA_W-1:0] imm;
        case (fmt)
            fmt_i:   imm = {{20{instr[31]}}, instr[31:20]};
            fmt_s:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            fmt_b:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            fmt_u:   imm = {instr[31:12], 12'h000};
            fmt_j:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// ----------------------------------------------------------------------------
// Module: ctrl_decoder
// Purpose: Purely combinational RV32I decoder: raw instruction + pc into a
//          decoded_entry_t (control word, register indices, immediate,
//          illegal flag).
// Configuration: RV32M_EN -- when defined, op_reg with funct7=0000001 decodes
//          as the mul/div group (muldiv=1); otherwise it is flagged illegal.
// Ports:
//   instr  in   32      raw instruction
//   pc     in   DATA_W  instruction pc (passed through)
//   entry  out  decoded_entry_t
// ----------------------------------------------------------------------------
module ctrl_decoder
    import rv32i_types::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    output decoded_entry_t    entry
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    imm_format_t       fmt;
    rv32i_control_word ctrl;
    logic              illegal;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        ctrl        = '0;
        fmt         = fmt_none;
        illegal     = 1'b0;
        ctrl.opcode = opcode;
        ctrl.funct3 = funct3;
        ctrl.aluop  = alu_add;

        case (opcode)
            op_lui, op_auipc: begin
                fmt               = fmt_u;
                ctrl.regfile_load = 1'b1;
            end
            op_jal: begin
                fmt               = fmt_j;
                ctrl.regfile_load = 1'b1;
                ctrl.jump         = 1'b1;
            end
            op_jalr: begin
                fmt               = fmt_i;
                ctrl.regfile_load = 1'b1;
                ctrl.jump         = 1'b1;
                ctrl.uses_rs1     = 1'b1;
            end
            op_br: begin
                fmt           = fmt_b;
                ctrl.branch   = 1'b1;
                ctrl.uses_rs1 = 1'b1;
                ctrl.uses_rs2 = 1'b1;
            end
            op_load: begin
                fmt               = fmt_i;
                ctrl.mem_read     = 1'b1;
                ctrl.regfile_load = 1'b1;
                ctrl.uses_rs1     = 1'b1;
            end
            op_store: begin
                fmt           = fmt_s;
                ctrl.mem_write = 1'b1;
                ctrl.uses_rs1 = 1'b1;
                ctrl.uses_rs2 = 1'b1;
            end
            op_imm: begin
                fmt               = fmt_i;
                ctrl.regfile_load = 1'b1;
                ctrl.uses_rs1     = 1'b1;
                ctrl.alu_imm      = 1'b1;
                ctrl.aluop        = alu_ops'(funct3);
                ctrl.alt          = (funct3 == 3'b101) && funct7[5];  // srai
            end
            op_reg: begin
                ctrl.uses_rs1 = 1'b1;
                ctrl.uses_rs2 = 1'b1;
                ctrl.aluop    = alu_ops'(funct3);
                ctrl.alt      = funct7[5];
                if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV32M_EN
                    ctrl.muldiv       = 1'b1;
                    ctrl.regfile_load = 1'b1;
`else
                    illegal = 1'b1;
`endif
                end else begin
                    ctrl.regfile_load = 1'b1;
                end
            end
            op_csr: begin
                fmt               = fmt_i;
                ctrl.regfile_load = 1'b1;
                ctrl.uses_rs1     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // An illegal entry must not touch architectural state downstream.
        if (illegal) begin
            ctrl = '0;
            fmt  = fmt_none;
        end
        if (rd == 5'd0) begin
            ctrl.regfile_load = 1'b0;
        end
    end

    assign entry = '{ctrl:    ctrl,
                     pc:      pc,
                     imm:     imm_gen(instr, fmt),
                     rs1:     instr[19:15],
                     rs2:     instr[24:20],
                     rd:      rd,
                     illegal: illegal};

endmodule

// File: rtl/ctrl_decode_queue.sv
// ----------------------------------------------------------------------------
// Module: ctrl_decode_queue
// Purpose: Registered decode stage. Fetched instructions are decoded on entry
//          and buffered in a DEPTH-entry FIFO feeding execute. Supports flush,
//          illegal-opcode flagging, rd==x0 write suppression and a one-bubble
//          load-use interlock on the head entry.
// Configuration: RV32M_EN (see ctrl_decoder) enables mul/div decode.
// Parameters: XLEN (pc/imm width, 32), DEPTH (FIFO depth, power of two >= 2)
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    discard queue and this cycle's input
//   in_valid/in_ready        fetch handshake
//   in_instr, in_pc          instruction and its pc
//   out_valid/out_ready      execute handshake
//   out_ctrl                 control word of head
//   out_pc, out_imm          head pc, sign-extended immediate
//   out_rs1/out_rs2/out_rd   head register indices
//   out_illegal              head opcode not recognised
// ----------------------------------------------------------------------------
module ctrl_decode_queue
    import rv32i_types::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output rv32i_control_word out_ctrl,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {st_run, st_bubble} lu_state_t;

    decoded_entry_t dec;
    decoded_entry_t head;
    decoded_entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    lu_state_t        state, state_next;
    logic [4:0]       last_load_rd, last_load_rd_next;
    logic             fifo_valid, hazard, push, pop;

    ctrl_decoder u_decoder (
        .instr (in_instr),
        .pc    (DATA_W'(in_pc)),
        .entry (dec)
    );

    // Empty queue presents the all-zero word so reset/idle outputs are defined.
    assign fifo_valid = (count != '0);
    assign head       = fifo_valid ? mem[rd_ptr] : '0;

    // last_load_rd is never x0 while in BUBBLE, so x0 sources cannot match.
    assign hazard = (state == st_bubble) && fifo_valid &&
                    ((head.ctrl.uses_rs1 && (head.rs1 == last_load_rd)) ||
                     (head.ctrl.uses_rs2 && (head.rs2 == last_load_rd)));

    assign out_valid = fifo_valid && !hazard;
    assign in_ready  = (count < FULL) || (out_valid && out_ready);
    assign pop       = out_valid && out_ready && !flush;
    assign push      = in_valid && in_ready && !flush;

    assign out_ctrl    = head.ctrl;
    assign out_pc      = XLEN'(head.pc);
    assign out_imm     = XLEN'($signed(head.imm));
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_illegal = head.illegal;

    // Interlock: a popped load arms one bubble cycle; the FSM always returns
    // to RUN after that single cycle whether or not the head was blocked.
    always_comb begin
        state_next        = st_run;
        last_load_rd_next = last_load_rd;
        if (flush) begin
            last_load_rd_next = '0;
        end else if (pop && head.ctrl.mem_read && (head.rd != 5'd0)) begin
            state_next        = st_bubble;
            last_load_rd_next = head.rd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            state        <= st_run;
            last_load_rd <= '0;
        end else begin
            state        <= state_next;
            last_load_rd <= last_load_rd_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: storage is deliberately not reset; validity comes solely from
    // count, which is reset, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

endmodule
